// File: rtl/axi_id_slot_table_if.sv
// rtl/axi_id_slot_table_if.sv - allocate/release bundle between a bridge and its ID slot table
interface axi_id_slot_table_if #(
    parameter int ID_WIDTH_IN  = 8,
    parameter int ID_WIDTH_OUT = 4
);
    logic [ID_WIDTH_IN-1:0]  alloc_id_i;
    logic [ID_WIDTH_OUT-1:0] alloc_id_o;
    logic                    full_o;
    logic                    alloc_i;
    logic [ID_WIDTH_OUT-1:0] rel_id_i;
    logic [ID_WIDTH_IN-1:0]  orig_id_o;
    logic                    rel_hit_o;
    logic                    release_i;
    logic                    empty_o;

    modport master (
        output alloc_id_i, alloc_i, rel_id_i, release_i,
        input  alloc_id_o, full_o, orig_id_o, rel_hit_o, empty_o
    );

    modport slave (
        input  alloc_id_i, alloc_i, rel_id_i, release_i,
        output alloc_id_o, full_o, orig_id_o, rel_hit_o, empty_o
    );
endinterface

// File: rtl/axi_id_slot_table.sv
// rtl/axi_id_slot_table.sv - maps wide AXI IDs onto narrow slot IDs and back, with per-slot outstanding counts
module axi_id_slot_table #(
    parameter int ID_WIDTH_IN  = 8,
    parameter int ID_WIDTH_OUT = 4,
    parameter int ID_SLOT      = 16,
    parameter int MAX_TXN      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_id_slot_table_if.slave  tbl
);
    localparam int CNT_W  = $clog2(MAX_TXN + 1);
    localparam int SLOT_W = (ID_SLOT > 1) ? $clog2(ID_SLOT) : 1;

    typedef logic [CNT_W-1:0]       cnt_t;
    typedef logic [SLOT_W-1:0]      slot_t;
    typedef logic [ID_WIDTH_IN-1:0] wid_t;

    cnt_t cnt_q [ID_SLOT];
    cnt_t cnt_d [ID_SLOT];
    wid_t id_q  [ID_SLOT];
    wid_t id_d  [ID_SLOT];

    logic  match_hit;
    slot_t match_idx;
    logic  free_hit;
    slot_t free_idx;
    slot_t alloc_idx;
    logic  full;
    logic  rel_in_range;
    slot_t rel_idx;
    logic  rel_hit;
    wid_t  orig_id;
    logic  empty;
    logic  do_commit;
    logic  do_retire;

    // Scan from the top so the last assignment wins with the lowest index.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        empty     = 1'b1;
        for (int s = ID_SLOT - 1; s >= 0; s--) begin
            if (cnt_q[s] != '0 && id_q[s] == tbl.alloc_id_i) begin
                match_hit = 1'b1;
                match_idx = slot_t'(s);
            end
            if (cnt_q[s] == '0) begin
                free_hit = 1'b1;
                free_idx = slot_t'(s);
            end else begin
                empty = 1'b0;
            end
        end
    end

    always_comb begin
        alloc_idx = '0;
        full      = 1'b0;
        if (match_hit) begin
            alloc_idx = match_idx;
            full      = (cnt_q[match_idx] == cnt_t'(MAX_TXN));
        end else if (free_hit) begin
            alloc_idx = free_idx;
        end else begin
            full      = 1'b1;
        end
    end

    always_comb begin
        rel_in_range = (32'(tbl.rel_id_i) < 32'(ID_SLOT));
        rel_idx      = slot_t'(tbl.rel_id_i);
        rel_hit      = 1'b0;
        orig_id      = '0;
        if (rel_in_range) begin
            rel_hit = (cnt_q[rel_idx] != '0);
            orig_id = id_q[rel_idx];
        end
    end

    assign do_commit = tbl.alloc_i && !full;
    assign do_retire = tbl.release_i && rel_hit;

    // Commit and retire both judge against pre-edge state; on the same slot they cancel.
    always_comb begin
        for (int s = 0; s < ID_SLOT; s++) begin
            cnt_d[s] = cnt_q[s];
            id_d[s]  = id_q[s];
        end
        for (int s = 0; s < ID_SLOT; s++) begin
            if (do_commit && alloc_idx == slot_t'(s) &&
                !(do_retire && rel_idx == slot_t'(s))) begin
                cnt_d[s] = cnt_q[s] + cnt_t'(1);
                if (cnt_q[s] == '0) begin
                    id_d[s] = tbl.alloc_id_i;
                end
            end else if (do_retire && rel_idx == slot_t'(s) &&
                         !(do_commit && alloc_idx == slot_t'(s))) begin
                cnt_d[s] = cnt_q[s] - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < ID_SLOT; s++) begin
                cnt_q[s] <= '0;
                id_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < ID_SLOT; s++) begin
                cnt_q[s] <= cnt_d[s];
                id_q[s]  <= id_d[s];
            end
        end
    end

    assign tbl.alloc_id_o = ID_WIDTH_OUT'(alloc_idx);
    assign tbl.full_o     = full;
    assign tbl.orig_id_o  = orig_id;
    assign tbl.rel_hit_o  = rel_hit;
    assign tbl.empty_o    = empty;
endmodule

// File: tb/tb_axi_id_slot_table.sv
// tb/tb_axi_id_slot_table.sv - randomized and directed checks of axi_id_slot_table against a table model
module tb_axi_id_slot_table;
    localparam int IWI = 8;
    localparam int IWO = 4;
    localparam int NS  = 16;
    localparam int MT  = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   mcnt [NS];
    int   mid  [NS];

    axi_id_slot_table_if #(.ID_WIDTH_IN(IWI), .ID_WIDTH_OUT(IWO)) bus ();

    axi_id_slot_table #(
        .ID_WIDTH_IN (IWI),
        .ID_WIDTH_OUT(IWO),
        .ID_SLOT     (NS),
        .MAX_TXN     (MT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tbl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            mcnt[s] = 0;
            mid[s]  = 0;
        end
    endtask

    task automatic model_eval(output int a, output int f, output int o, output int h, output int e);
        int m;
        int fr;
        int r;
        m  = -1;
        fr = -1;
        e  = 1;
        for (int s = 0; s < NS; s++) begin
            if (m < 0 && mcnt[s] > 0 && mid[s] == int'(bus.alloc_id_i)) m = s;
            if (fr < 0 && mcnt[s] == 0) fr = s;
            if (mcnt[s] > 0) e = 0;
        end
        a = (m >= 0) ? m : ((fr >= 0) ? fr : 0);
        f = (m >= 0) ? int'(mcnt[m] == MT) : int'(fr < 0);
        r = int'(bus.rel_id_i);
        h = (r < NS) ? int'(mcnt[r] > 0) : 0;
        o = (r < NS) ? mid[r] : 0;
    endtask

    task automatic model_update();
        int a, f, o, h, e;
        int was_free;
        model_eval(a, f, o, h, e);
        was_free = int'(mcnt[a] == 0);
        if (bus.alloc_i && f == 0) begin
            mcnt[a]++;
            if (was_free != 0) mid[a] = int'(bus.alloc_id_i);
        end
        if (bus.release_i && h != 0) mcnt[int'(bus.rel_id_i)]--;
    endtask

    task automatic compare_all(input string tag);
        int a, f, o, h, e;
        model_eval(a, f, o, h, e);
        chk({tag, ".alloc_id_o"}, int'(bus.alloc_id_o), a);
        chk({tag, ".full_o"},     int'(bus.full_o),     f);
        chk({tag, ".orig_id_o"},  int'(bus.orig_id_o),  o);
        chk({tag, ".rel_hit_o"},  int'(bus.rel_hit_o),  h);
        chk({tag, ".empty_o"},    int'(bus.empty_o),    e);
    endtask

    // Compare mid-cycle, advance the model at the edge, return just after it.
    task automatic cycle();
        @(negedge clk);
        compare_all("cyc");
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic set_in(input int aid, input bit al, input int rid, input bit rl);
        bus.alloc_id_i = aid[IWI-1:0];
        bus.alloc_i    = al;
        bus.rel_id_i   = rid[IWO-1:0];
        bus.release_i  = rl;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        set_in(0, 0, 0, 0);
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        model_clear();
        set_in(0, 0, 0, 0);
        chk("rst.alloc_id_o", int'(bus.alloc_id_o), 0);
        chk("rst.full_o",     int'(bus.full_o),     0);
        chk("rst.empty_o",    int'(bus.empty_o),    1);
        chk("rst.orig_id_o",  int'(bus.orig_id_o),  0);
        chk("rst.rel_hit_o",  int'(bus.rel_hit_o),  0);
        cycle();
        rst_n = 1'b1;
        cycle();

        set_in('h11, 1, 0, 0); chk("seq.0x11", int'(bus.alloc_id_o), 0); cycle();
        set_in('h22, 1, 0, 0); chk("seq.0x22", int'(bus.alloc_id_o), 1); cycle();
        set_in('h33, 1, 0, 0); chk("seq.0x33", int'(bus.alloc_id_o), 2); cycle();
        set_in('h11, 0, 0, 0); chk("seq.empty", int'(bus.empty_o), 0);

        for (int i = 0; i < 3; i++) begin
            set_in('h11, 1, 0, 0);
            chk("rep.alloc", int'(bus.alloc_id_o), 0);
            cycle();
        end
        set_in('h11, 1, 0, 0); chk("rep.full_11", int'(bus.full_o), 1);
        set_in('h44, 0, 0, 0); chk("rep.full_44", int'(bus.full_o), 0);
        chk("rep.alloc_44", int'(bus.alloc_id_o), 3);
        cycle();

        do_reset();
        for (int i = 0; i < NS; i++) begin
            set_in('h40 + i, 1, 0, 0);
            cycle();
        end
        set_in('h80, 1, 0, 0); chk("fill.full", int'(bus.full_o), 1);
        cycle();
        set_in('h80, 0, 5, 1); chk("fill.hit5", int'(bus.rel_hit_o), 1);
        cycle();
        set_in('h90, 0, 5, 0);
        chk("fill.reuse5", int'(bus.alloc_id_o), 5);
        chk("fill.notfull", int'(bus.full_o), 0);
        chk("fill.stale5", int'(bus.orig_id_o), 'h45);
        cycle();

        do_reset();
        for (int i = 0; i < NS; i++) begin
            set_in((i == 3) ? 'hA7 : 'h40 + i, 1, 0, 0);
            cycle();
        end
        set_in('hB0, 1, 3, 1); chk("same.full", int'(bus.full_o), 1);
        cycle();
        set_in('hB0, 0, 3, 0);
        chk("same.freed", int'(bus.rel_hit_o), 0);
        chk("same.alloc3", int'(bus.alloc_id_o), 3);
        chk("same.nofull", int'(bus.full_o), 0);
        cycle();

        do_reset();
        set_in('h10, 1, 0, 0); cycle();
        set_in('h20, 1, 0, 0); cycle();
        set_in('h5C, 1, 0, 0); cycle();
        set_in(0, 0, 9, 1); chk("rel9.hit", int'(bus.rel_hit_o), 0);
        cycle();
        set_in(0, 0, 2, 0);
        chk("rel2.orig", int'(bus.orig_id_o), 'h5C);
        chk("rel2.hit",  int'(bus.rel_hit_o), 1);
        chk("rel9.empty", int'(bus.empty_o), 0);
        cycle();

        do_reset();
        for (int n = 0; n < 2000; n++) begin
            set_in($urandom_range(0, 19), ($urandom_range(0, 9) < 7),
                   $urandom_range(0, NS - 1), ($urandom_range(0, 1) == 1));
            cycle();
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in('h60 + (i % 3), 1, 0, 0);
            cycle();
        end
        set_in('h61, 1, 1, 1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst.alloc_id_o", int'(bus.alloc_id_o), 0);
        chk("arst.full_o",     int'(bus.full_o),     0);
        chk("arst.empty_o",    int'(bus.empty_o),    1);
        chk("arst.orig_id_o",  int'(bus.orig_id_o),  0);
        chk("arst.rel_hit_o",  int'(bus.rel_hit_o),  0);
        cycle();
        rst_n = 1'b1;
        set_in('h11, 1, 0, 0); chk("arst.after", int'(bus.alloc_id_o), 0);
        cycle();
        set_in(0, 0, 0, 0);
        chk("arst.orig0", int'(bus.orig_id_o), 'h11);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
